// File: rtl/wrap_evq_pkg.sv
// Shared types and constants for the overflow event queue.
// WRAP_EVQ_TIMESTAMP_EN adds a timestamp field to each entry.
package wrap_evq_pkg;

  localparam int unsigned DEPTH_DEFAULT = 4;
  localparam int unsigned SEQ_W_DEFAULT = 8;
  localparam int unsigned TS_W_DEFAULT  = 16;

  localparam logic [7:0] DROP_MAX = 8'd255;

  typedef struct packed {
    logic [SEQ_W_DEFAULT-1:0] seq;
`ifdef WRAP_EVQ_TIMESTAMP_EN
    logic [TS_W_DEFAULT-1:0]  ts;
`endif
  } wrap_evt_t;

  function automatic bit is_pow2(input int unsigned v);
    return (v >= 2) && ((v & (v - 1)) == 0);
  endfunction

endpackage

// File: rtl/wrap_event_queue_if.sv
// Event drain handshake between the queue (master) and its consumer (slave).
// evt_ts exists only when WRAP_EVQ_TIMESTAMP_EN is defined.
interface wrap_event_queue_if
  import wrap_evq_pkg::*;
#(
  parameter int unsigned DEPTH = DEPTH_DEFAULT,
  parameter int unsigned SEQ_W = SEQ_W_DEFAULT,
  parameter int unsigned TS_W  = TS_W_DEFAULT
);

  logic                     evt_valid;
  logic                     evt_ready;
  logic [SEQ_W-1:0]         evt_seq;
`ifdef WRAP_EVQ_TIMESTAMP_EN
  logic [TS_W-1:0]          evt_ts;
`endif
  logic [$clog2(DEPTH):0]   evt_level;
  logic                     full;

  if (TS_W == 0) begin : g_ts_w_check
    $error("wrap_event_queue_if: TS_W must be nonzero");
  end

  modport master (
    input  evt_ready,
`ifdef WRAP_EVQ_TIMESTAMP_EN
    output evt_ts,
`endif
    output evt_valid, evt_seq, evt_level, full
  );

  modport slave (
    output evt_ready,
`ifdef WRAP_EVQ_TIMESTAMP_EN
    input  evt_ts,
`endif
    input  evt_valid, evt_seq, evt_level, full
  );

endinterface

// File: rtl/wrap_evq_fifo.sv
// Generic synchronous FIFO; pointers carry one extra wrap bit so full and
// empty are told apart without a separate count register.
module wrap_evq_fifo
  import wrap_evq_pkg::*;
#(
  parameter type         T     = wrap_evt_t,
  parameter int unsigned DEPTH = DEPTH_DEFAULT
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   push_i,
  input  logic                   pop_i,
  input  T                       wdata_i,
  output T                       rdata_o,
  output logic [$clog2(DEPTH):0] level_o,
  output logic                   full_o,
  output logic                   empty_o
);

  localparam int unsigned AW = $clog2(DEPTH);

  T           mem_q [DEPTH];
  logic [AW:0] wr_ptr_q;
  logic [AW:0] rd_ptr_q;
  logic        do_push;
  logic        do_pop;

  assign empty_o = (wr_ptr_q == rd_ptr_q);
  assign full_o  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                   (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign level_o = wr_ptr_q - rd_ptr_q;

  // A pop frees the slot in the same cycle, so a full FIFO still accepts a push.
  assign do_pop  = pop_i & ~empty_o;
  assign do_push = push_i & (~full_o | do_pop);

  assign rdata_o = mem_q[rd_ptr_q[AW-1:0]];

  always_ff @(posedge clk) begin
    if (reset) begin
      mem_q    <= '{default: '0};
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      if (do_push) begin
        mem_q[wr_ptr_q[AW-1:0]] <= wdata_i;
        wr_ptr_q                <= wr_ptr_q + 1'b1;
      end
      if (do_pop) begin
        rd_ptr_q <= rd_ptr_q + 1'b1;
      end
    end
  end

endmodule

// File: rtl/wrap_event_queue.sv
// Rising-edge detector on the counter overflow flag feeding a sequence-tagged
// event FIFO with overrun accounting. WRAP_EVQ_TIMESTAMP_EN adds timestamps.
module wrap_event_queue
  import wrap_evq_pkg::*;
#(
  parameter int unsigned DEPTH = DEPTH_DEFAULT,
  parameter int unsigned SEQ_W = SEQ_W_DEFAULT,
  parameter int unsigned TS_W  = TS_W_DEFAULT
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                overflow_in,
  input  logic                clear_drop,
  output logic                drop_sticky,
  output logic [7:0]          drop_count,
  wrap_event_queue_if.master  evt
);

  typedef struct packed {
    logic [SEQ_W-1:0] seq;
`ifdef WRAP_EVQ_TIMESTAMP_EN
    logic [TS_W-1:0]  ts;
`endif
  } evt_t;

  if (!is_pow2(DEPTH)) begin : g_depth_check
    $error("wrap_event_queue: DEPTH must be a power of two >= 2");
  end
  if (TS_W == 0) begin : g_ts_w_check
    $error("wrap_event_queue: TS_W must be nonzero");
  end

  logic             ovf_q;
  logic [SEQ_W-1:0] seq_q;
`ifdef WRAP_EVQ_TIMESTAMP_EN
  logic [TS_W-1:0]  ts_q;
`endif
  logic [7:0]       drop_cnt_q, drop_cnt_d;
  logic             drop_sticky_q, drop_sticky_d;

  logic             event_det;
  logic             pop;
  logic             push;
  logic             drop;
  logic             fifo_full;
  logic             fifo_empty;
  evt_t             wdata;
  evt_t             rdata;

  assign event_det = overflow_in & ~ovf_q;
  assign pop       = ~fifo_empty & evt.evt_ready;
  assign push      = event_det & (~fifo_full | pop);
  assign drop      = event_det & fifo_full & ~pop;

  always_comb begin
    wdata     = '0;
    wdata.seq = seq_q;
`ifdef WRAP_EVQ_TIMESTAMP_EN
    wdata.ts  = ts_q;
`endif
  end

  // Clear is applied before the drop so a coincident drop still counts as one.
  always_comb begin
    drop_cnt_d    = drop_cnt_q;
    drop_sticky_d = drop_sticky_q;
    if (clear_drop) begin
      drop_cnt_d    = '0;
      drop_sticky_d = 1'b0;
    end
    if (drop) begin
      drop_sticky_d = 1'b1;
      if (drop_cnt_d != DROP_MAX) begin
        drop_cnt_d = drop_cnt_d + 8'd1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      ovf_q         <= 1'b1;
      seq_q         <= '0;
`ifdef WRAP_EVQ_TIMESTAMP_EN
      ts_q          <= '0;
`endif
      drop_cnt_q    <= '0;
      drop_sticky_q <= 1'b0;
    end else begin
      ovf_q         <= overflow_in;
      if (event_det) begin
        seq_q <= seq_q + 1'b1;
      end
`ifdef WRAP_EVQ_TIMESTAMP_EN
      ts_q          <= ts_q + 1'b1;
`endif
      drop_cnt_q    <= drop_cnt_d;
      drop_sticky_q <= drop_sticky_d;
    end
  end

  wrap_evq_fifo #(
    .T     (evt_t),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk     (clk),
    .reset   (reset),
    .push_i  (push),
    .pop_i   (pop),
    .wdata_i (wdata),
    .rdata_o (rdata),
    .level_o (evt.evt_level),
    .full_o  (fifo_full),
    .empty_o (fifo_empty)
  );

  assign evt.evt_valid = ~fifo_empty;
  assign evt.evt_seq   = rdata.seq;
`ifdef WRAP_EVQ_TIMESTAMP_EN
  assign evt.evt_ts    = rdata.ts;
`endif
  assign evt.full      = fifo_full;
  assign drop_count    = drop_cnt_q;
  assign drop_sticky   = drop_sticky_q;

endmodule

// File: tb/tb_wrap_event_queue.sv
// Self-checking bench for wrap_event_queue: queue-based reference model checked
// every cycle, directed scenarios with literal expectations, then random traffic.
module tb_wrap_event_queue;

  localparam int unsigned DEPTH = 4;
  localparam int unsigned SEQ_W = 8;
  localparam int unsigned TS_W  = 16;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       overflow_in = 1'b0;
  logic       clear_drop = 1'b0;
  logic       drop_sticky;
  logic [7:0] drop_count;

  wrap_event_queue_if #(.DEPTH(DEPTH), .SEQ_W(SEQ_W), .TS_W(TS_W)) evt_if ();

  wrap_event_queue #(.DEPTH(DEPTH), .SEQ_W(SEQ_W), .TS_W(TS_W)) dut (
    .clk         (clk),
    .reset       (reset),
    .overflow_in (overflow_in),
    .clear_drop  (clear_drop),
    .drop_sticky (drop_sticky),
    .drop_count  (drop_count),
    .evt         (evt_if)
  );

  always #5 clk = ~clk;

  typedef struct {
    int seq;
    int ts;
  } ent_t;

  ent_t mq[$];
  int   m_seq = 0;
  int   m_ts = 0;
  int   m_drops = 0;
  bit   m_prev = 1'b1;
  bit   m_sticky = 1'b0;

  int   n_vec = 0;
  int   n_err = 0;
  bit   cmp_en = 1'b0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d (0x%0h), expected %0d at %0t", nm, act, act, exp, $time);
    end
  endtask

  // Reference behaviour for one clock edge, from the sampled inputs.
  function automatic void model_step(input bit ovf, input bit rdy, input bit clr, input bit rst);
    bit ev, was_full, pop, drop;
    if (rst) begin
      mq.delete();
      m_seq = 0; m_ts = 0; m_drops = 0; m_prev = 1'b1; m_sticky = 1'b0;
      return;
    end
    ev       = ovf && !m_prev;
    was_full = (mq.size() == DEPTH);
    pop      = (mq.size() != 0) && rdy;
    if (pop) void'(mq.pop_front());
    drop = ev && was_full && !pop;
    if (ev && !drop) mq.push_back('{seq: m_seq, ts: m_ts});
    if (clr) begin
      m_drops = 0; m_sticky = 1'b0;
    end
    if (drop) begin
      m_sticky = 1'b1;
      if (m_drops < 255) m_drops++;
    end
    if (ev) m_seq = (m_seq + 1) % (1 << SEQ_W);
    m_ts   = (m_ts + 1) % (1 << TS_W);
    m_prev = ovf;
  endfunction

  always @(negedge clk) begin
    if (cmp_en) begin
      chk("evt_valid", {31'd0, evt_if.evt_valid}, {31'd0, mq.size() != 0});
      chk("evt_level", 32'(evt_if.evt_level), mq.size());
      chk("full", {31'd0, evt_if.full}, {31'd0, mq.size() == DEPTH});
      chk("drop_count", 32'(drop_count), m_drops);
      chk("drop_sticky", {31'd0, drop_sticky}, {31'd0, m_sticky});
      if (mq.size() != 0) begin
        chk("evt_seq", 32'(evt_if.evt_seq), mq[0].seq);
`ifdef WRAP_EVQ_TIMESTAMP_EN
        chk("evt_ts", 32'(evt_if.evt_ts), mq[0].ts);
`endif
      end
    end
  end

  task automatic cyc(input bit ovf, input bit rdy, input bit clr, input bit rst);
    @(negedge clk);
    overflow_in      = ovf;
    evt_if.evt_ready = rdy;
    clear_drop       = clr;
    reset            = rst;
    @(posedge clk);
    model_step(ovf, rdy, clr, rst);
    #1;
  endtask

  task automatic do_reset();
    cyc(0, 0, 0, 1);
    cyc(0, 0, 0, 1);
    cyc(0, 0, 0, 0);
  endtask

  task automatic edges(input int n, input bit rdy);
    for (int i = 0; i < n; i++) begin
      cyc(1, rdy, 0, 0);
      cyc(0, rdy, 0, 0);
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    evt_if.evt_ready = 1'b0;
    cyc(0, 0, 0, 1);
    cmp_en = 1'b1;
    do_reset();

    chk("rst_valid", {31'd0, evt_if.evt_valid}, 0);
    chk("rst_level", 32'(evt_if.evt_level), 0);
    chk("rst_full", {31'd0, evt_if.full}, 0);
    chk("rst_seq", 32'(evt_if.evt_seq), 0);
    chk("rst_dcount", 32'(drop_count), 0);
    chk("rst_sticky", {31'd0, drop_sticky}, 0);
`ifdef WRAP_EVQ_TIMESTAMP_EN
    chk("rst_ts", 32'(evt_if.evt_ts), 0);
`endif

    // Single event
    cyc(1, 1, 0, 0);
    chk("single_valid", {31'd0, evt_if.evt_valid}, 1);
    chk("single_seq", 32'(evt_if.evt_seq), 0);
`ifdef WRAP_EVQ_TIMESTAMP_EN
    chk("single_ts", 32'(evt_if.evt_ts), 1);
`endif
    cyc(0, 1, 0, 0);
    chk("single_gone", {31'd0, evt_if.evt_valid}, 0);

    // Held flag
    do_reset();
    for (int i = 0; i < 20; i++) cyc(1, 0, 0, 0);
    cyc(0, 0, 0, 0);
    chk("held_level", 32'(evt_if.evt_level), 1);
    chk("held_seq", 32'(evt_if.evt_seq), 0);
    chk("held_model_seq", m_seq, 1);

    // Overrun
    do_reset();
    edges(6, 0);
    chk("ovr_full", {31'd0, evt_if.full}, 1);
    chk("ovr_level", 32'(evt_if.evt_level), 4);
    chk("ovr_dcount", 32'(drop_count), 2);
    chk("ovr_sticky", {31'd0, drop_sticky}, 1);
    for (int i = 0; i < 4; i++) begin
      chk("ovr_drain_seq", 32'(evt_if.evt_seq), i);
      cyc(0, 1, 0, 0);
    end
    chk("ovr_empty", {31'd0, evt_if.evt_valid}, 0);
    cyc(1, 0, 0, 0);
    chk("ovr_next_seq", 32'(evt_if.evt_seq), 6);

    // Full with simultaneous pop
    do_reset();
    edges(4, 0);
    cyc(1, 1, 0, 0);
    chk("fp_level", 32'(evt_if.evt_level), 4);
    chk("fp_full", {31'd0, evt_if.full}, 1);
    chk("fp_dcount", 32'(drop_count), 0);
    for (int i = 1; i <= 4; i++) begin
      chk("fp_drain_seq", 32'(evt_if.evt_seq), i);
      cyc(0, 1, 0, 0);
    end
    chk("fp_level_end", 32'(evt_if.evt_level), 0);

    // Saturation and clear
    do_reset();
    edges(304, 0);
    chk("sat_dcount", 32'(drop_count), 255);
    chk("sat_sticky", {31'd0, drop_sticky}, 1);
    cyc(1, 0, 1, 0);
    chk("clr_drop_dcount", 32'(drop_count), 1);
    chk("clr_drop_sticky", {31'd0, drop_sticky}, 1);
    cyc(0, 0, 1, 0);
    chk("clr_dcount", 32'(drop_count), 0);
    chk("clr_sticky", {31'd0, drop_sticky}, 0);

    // Reset mid-operation, with an edge landing in the reset cycle
    do_reset();
    edges(3, 0);
    chk("mid_level_pre", 32'(evt_if.evt_level), 3);
    cyc(1, 0, 0, 1);
    chk("mid_valid", {31'd0, evt_if.evt_valid}, 0);
    chk("mid_level", 32'(evt_if.evt_level), 0);
    cyc(1, 0, 0, 0);
    chk("mid_edge_ignored", 32'(evt_if.evt_level), 0);
    cyc(0, 0, 0, 0);
    cyc(1, 0, 0, 0);
    chk("mid_next_valid", {31'd0, evt_if.evt_valid}, 1);
    chk("mid_next_seq", 32'(evt_if.evt_seq), 0);

    // Random traffic; ready bias alternates so the queue both fills and drains
    do_reset();
    for (int i = 0; i < 2000; i++) begin
      bit rdy_bias;
      rdy_bias = ((i / 200) % 2) == 0;
      cyc($urandom_range(0, 1) == 1,
          rdy_bias ? ($urandom_range(0, 3) != 0) : ($urandom_range(0, 3) == 0),
          $urandom_range(0, 19) == 0,
          $urandom_range(0, 199) == 0);
    end
    cyc(0, 1, 0, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/wrap_event_queue.md
# wrap_event_queue

Downstream consumer of the 4-bit up-counter's overflow output. Detects each rising edge of the counter's overflow flag, tags it with a sequence number and an optional free-running timestamp, and buffers the events in a small FIFO. Events drain over a valid/ready handshake, and overruns are reported through a drop counter.

## Interface
Parameters:
- DEPTH, 4, FIFO entries; must be a power of two, at least 2
- SEQ_W, 8, sequence-number width
- TS_W, 16, timestamp width (used only when the timestamp feature is compiled in)

Ports:
- clk  input  1  clock; all logic is on the rising edge
- reset  input  1  synchronous, active-high reset
- overflow_in  input  1  overflow flag from the counter
- evt_valid  output  1  head entry is valid
- evt_ready  input  1  consumer accepts the head entry
- evt_seq  output  SEQ_W  sequence number of the head entry
- evt_ts  output  TS_W  timestamp of the head entry (timestamp build only)
- evt_level  output  $clog2(DEPTH)+1  current occupancy
- full  output  1  occupancy == DEPTH
- drop_sticky  output  1  at least one event was lost since the last clear
- drop_count  output  8  number of lost events; saturates at 255
- clear_drop  input  1  clears drop_sticky and drop_count

## Operation
- **Edge detect.** Register ovf_q holds the previous overflow_in.
  - ovf_q resets to 1, so a flag already high out of reset is not counted.
  - An event occurs when overflow_in & ~ovf_q.
  - A flag held high yields exactly one event.
- **Sequence counter.** seq_ctr increments on every detected event, including dropped events.
  - It wraps modulo 2^SEQ_W.
  - The consumer infers losses from gaps in evt_seq.
- **Timestamp.** ts_ctr is a free-running counter that increments every cycle and wraps at 2^TS_W.
  - An entry stores the ts_ctr value from the cycle its event was detected.
- **Push.** An event is pushed if the FIFO is not full, or if a pop happens in the same cycle.
  - The pushed entry holds {seq_ctr, ts_ctr} as they are before incrementing.
- **Drop.** An event is dropped if the FIFO is full and there is no pop that cycle.
  - drop_sticky is set to 1.
  - drop_count increments, saturating at 255.
- **Clear.** clear_drop zeroes drop_sticky and drop_count.
  - If clear_drop and a drop occur in the same cycle, the result is drop_count=1 and drop_sticky=1.
- **Pop.** A pop occurs when evt_valid & evt_ready.
  - evt_seq and evt_ts are stable while evt_valid=1 and evt_ready=0.
- **FIFO.** Circular buffer with wr_ptr and rd_ptr, each one bit wider than the index.
  - empty: the pointers are equal.
  - full: the pointers differ only in the MSB.
- **Empty FIFO.** When empty, evt_valid=0 and the data outputs hold their last value (don't-care).

## Timing
- **Reset values:**
  - evt_valid=0, evt_level=0, full=0.
  - drop_sticky=0, drop_count=0.
  - evt_seq=0, evt_ts=0.
  - seq_ctr=0, ts_ctr=0, ovf_q=1.
- **Latency.** An event detected in cycle N is at the head with evt_valid=1 in cycle N+1 if the FIFO was empty.
- **Throughput.** One push and one pop per cycle.
- **Occupancy.** evt_level and full update in the cycle after the push or pop.
- **Reset mid-operation.** Reset flushes all entries and restarts both counters from 0.
  - An edge on overflow_in in the reset cycle is ignored.

## Configuration
- Macro: WRAP_EVQ_TIMESTAMP_EN.
- **Defined:**
  - The ts_ctr counter and the evt_ts port exist.
  - Entries are SEQ_W+TS_W bits wide.
- **Undefined:**
  - There is no ts_ctr and no evt_ts port.
  - Entries are SEQ_W bits wide.
  - All other behaviour is identical.

## Structure
- Shared package wrap_evq_pkg contains:
  - the default DEPTH, SEQ_W and TS_W constants;
  - typedef wrap_evt_t, a packed struct {seq, ts} with the ts field under the macro;
  - DROP_MAX = 8'd255.
- Sub-module wrap_evq_fifo: a generic synchronous FIFO with parameterised entry type and DEPTH.
  - It provides push/pop, level and full/empty.
- The top level contains the edge detect, the counters, the drop logic and the FIFO instance.

## Test plan
- **Single event:** reset, then pulse overflow_in for 1 cycle with evt_ready=1.
  - Expect evt_valid=1 for one cycle, the cycle after detection, with evt_seq=0.
  - With the timestamp feature, evt_ts equals ts_ctr in the detection cycle.
- **Held flag:** hold overflow_in=1 for 20 cycles.
  - Expect exactly one event; seq_ctr ends at 1.
- **Overrun:** evt_ready=0, 6 edges with DEPTH=4.
  - Expect full=1, drop_count=2, drop_sticky=1.
  - Draining yields seq 0,1,2,3; the next edge gets seq 6.
- **Full with simultaneous pop:** FIFO full, evt_ready=1 and an edge in the same cycle.
  - Expect no drop, evt_level stays 4, and the new entry is queued last.
- **Drop counter saturation and clear:** 300 drops.
  - Expect drop_count=255.
  - clear_drop in the same cycle as a drop gives drop_count=1, drop_sticky=1.
- **Reset mid-operation:** reset with 3 entries queued.
  - Expect evt_valid=0 and evt_level=0 the next cycle; the next event has seq 0.
